// File: rtl/scrypt_pkg.sv
// rtl/scrypt_pkg.sv - shared types and helpers for the scrypt Salsa20 datapath
package scrypt_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } salsa_state_t;

  localparam int SALSA_WORDS = 16;

  function automatic word_t rotl32(input word_t v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/salsa_quarterround.sv
// rtl/salsa_quarterround.sv - combinational Salsa20 quarter-round on (a,b,c,d) = (x[0],x[1],x[2],x[3])
module salsa_quarterround
  import scrypt_pkg::*;
(
  input  word_t [3:0] x,
  output word_t [3:0] y
);

  word_t a, b, c, d;

  // Each step consumes the freshly updated word from the previous step.
  always_comb begin
    b = x[1] ^ rotl32(x[0] + x[3], 7);
    c = x[2] ^ rotl32(b + x[0], 9);
    d = x[3] ^ rotl32(c + b, 13);
    a = x[0] ^ rotl32(d + c, 18);
    y = {d, c, b, a};
  end

endmodule

// File: rtl/salsa20_8_iter.sv
// rtl/salsa20_8_iter.sv - iterative Salsa20/ROUNDS core, one round per clock, enable/hash_done responder
module salsa20_8_iter
  import scrypt_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [511:0] data,
  input  logic         enable,
  output logic [511:0] data_out,
  output logic         hash_done
);

  localparam int RW = $clog2(ROUNDS);

  salsa_state_t                  state;
  logic [RW-1:0]                 rcnt;
  word_t [SALSA_WORDS-1:0]       b_reg;
  word_t [SALSA_WORDS-1:0]       x;
  word_t [SALSA_WORDS-1:0]       round_x;
  word_t [SALSA_WORDS-1:0]       result;
  word_t [3:0]                   qin  [4];
  word_t [3:0]                   qout [4];

  // Column tuple q, slot k reads word 4*((q+k)%4)+q; the row tuple is its transpose.
  for (genvar q = 0; q < 4; q++) begin : g_qr
    for (genvar k = 0; k < 4; k++) begin : g_slot
      localparam int CI = 4 * ((q + k) % 4) + q;
      localparam int RI = 4 * q + ((q + k) % 4);
      assign qin[q][k] = rcnt[0] ? x[RI] : x[CI];
    end
    salsa_quarterround u_qr (
      .x(qin[q]),
      .y(qout[q])
    );
  end

  for (genvar w = 0; w < SALSA_WORDS; w++) begin : g_word
    localparam int RQ = w / 4;
    localparam int RK = ((w % 4) - (w / 4) + 4) % 4;
    localparam int CQ = w % 4;
    localparam int CK = ((w / 4) - (w % 4) + 4) % 4;
    assign round_x[w] = rcnt[0] ? qout[RQ][RK] : qout[CQ][CK];
    assign result[w]  = round_x[w] + b_reg[w];
  end

  assign hash_done = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rcnt     <= '0;
      b_reg    <= '0;
      x        <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            b_reg <= data;
            x     <= data;
            rcnt  <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          x    <= round_x;
          rcnt <= rcnt + 1'b1;
          if (rcnt == RW'(ROUNDS - 1)) begin
            data_out <= result;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_salsa20_8_iter.sv
// tb/tb_salsa20_8_iter.sv - self-checking bench for salsa20_8_iter against a Salsa20/8 reference model
module tb_salsa20_8_iter;

  localparam int ROUNDS = 8;
  localparam int LAT    = ROUNDS + 1;

  // Salsa20 quarter-round tuples: four column tuples followed by four row tuples.
  localparam int TUP [8][4] = '{
    '{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
    '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}
  };

  logic         clk = 1'b0;
  logic         n_rst;
  logic [511:0] data;
  logic         enable;
  logic [511:0] data_out;
  logic         hash_done;

  int vectors = 0;
  int miscompares = 0;

  logic [511:0] rfc_in;
  logic [511:0] rfc_out;
  logic [511:0] blk;
  logic [511:0] expv;
  logic [31:0]  w0;
  int           lat;
  int           cnt;

  salsa20_8_iter #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .data(data),
    .enable(enable),
    .data_out(data_out),
    .hash_done(hash_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] salsa_ref(input logic [511:0] blk_in);
    logic [31:0]  w   [16];
    logic [31:0]  org [16];
    logic [511:0] res;
    int a, b, c, d;
    for (int i = 0; i < 16; i++) begin
      w[i]   = blk_in[32*i +: 32];
      org[i] = w[i];
    end
    for (int dr = 0; dr < ROUNDS / 2; dr++) begin
      for (int g = 0; g < 8; g++) begin
        a = TUP[g][0]; b = TUP[g][1]; c = TUP[g][2]; d = TUP[g][3];
        w[b] = w[b] ^ rotl(w[a] + w[d], 7);
        w[c] = w[c] ^ rotl(w[b] + w[a], 9);
        w[d] = w[d] ^ rotl(w[c] + w[b], 13);
        w[a] = w[a] ^ rotl(w[d] + w[c], 18);
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = w[i] + org[i];
    return res;
  endfunction

  // Byte string (first byte in the MSBs) to little-endian word packing.
  function automatic logic [511:0] bytes_to_block(input logic [511:0] s);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = s[511 - 8*k -: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just before the intended capture edge; returns at the negedge of cycle 1.
  task automatic request(input logic [511:0] b);
    data   = b;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  // Counts cycles from 'start' until hash_done is seen; 999 on timeout.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!hash_done && cyc < start + 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!hash_done) cyc = 999;
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      if (hash_done) c++;
      @(negedge clk);
    end
  endtask

  initial begin
    rfc_in  = bytes_to_block(512'h7e879a214f3ec9867ca940e641718f26baee555b8c61c1b50df846116dcd3b1dee24f319df9b3d8514121e4b5ac5aa3276021d2909c74829edebc68db8b8c25e);
    rfc_out = bytes_to_block(512'ha41f859c6608cc993b81cacb020cef05044b2181a2fd337dfd7b1c6396682f29b4393168e3c9e6bcfe6bc5b7a06d96bae424cc102c91745c24ad673dc7618f81);
    n_rst = 1'b0; enable = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    check("reset_done", 512'(hash_done), 512'(0));
    check("reset_out", data_out, '0);
    n_rst = 1'b1;
    @(negedge clk);

    // RFC 7914 Salsa20/8 vector, single request
    request(rfc_in);
    wait_done(1, lat);
    check("rfc_latency", 512'(lat), 512'(LAT));
    check("rfc_out", data_out, rfc_out);
    w0 = data_out[31:0];
    check("rfc_word0", 512'(w0), 512'(32'h9c851fa4));
    check("rfc_model", data_out, salsa_ref(rfc_in));
    @(negedge clk);
    check("rfc_pulse_width", 512'(hash_done), 512'(0));
    check("rfc_hold", data_out, rfc_out);

    // All-zero input
    request('0);
    wait_done(1, lat);
    check("zero_latency", 512'(lat), 512'(LAT));
    check("zero_out", data_out, '0);
    @(negedge clk);

    // Randomized blocks against the reference model
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
      request(blk);
      wait_done(1, lat);
      check("rand_latency", 512'(lat), 512'(LAT));
      check("rand_out", data_out, salsa_ref(blk));
      @(negedge clk);
    end

    // Back-to-back with enable held, data switched on hash_done
    data = rfc_in; enable = 1'b1;
    @(negedge clk);
    wait_done(1, lat);
    check("b2b_first_latency", 512'(lat), 512'(LAT));
    check("b2b_first_out", data_out, rfc_out);
    data = '0;
    @(negedge clk);
    wait_done(1, lat);
    enable = 1'b0;
    check("b2b_spacing", 512'(lat), 512'(ROUNDS + 2));
    check("b2b_second_out", data_out, '0);
    @(negedge clk);
    count_done(15, cnt);
    check("b2b_no_extra", 512'(cnt), 512'(0));

    // Input stability: data and enable wiggle during ROUND
    request(rfc_in);
    for (int c = 1; c <= 6; c++) begin
      for (int i = 0; i < 16; i++) data[32*i +: 32] = $urandom();
      enable = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    enable = 1'b0;
    wait_done(7, lat);
    check("stable_latency", 512'(lat), 512'(LAT));
    check("stable_out", data_out, rfc_out);
    @(negedge clk);
    count_done(20, cnt);
    check("stable_no_extra", 512'(cnt), 512'(0));

    // Reset in cycle 4 of ROUND, then quiet period, then a fresh request
    request(rfc_in);
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midreset_done", 512'(hash_done), 512'(0));
    check("midreset_out", data_out, '0);
    @(negedge clk);
    n_rst = 1'b1;
    count_done(20, cnt);
    check("midreset_quiet", 512'(cnt), 512'(0));
    check("midreset_out_after", data_out, '0);
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
    expv = salsa_ref(blk);
    request(blk);
    repeat (3) @(negedge clk);
    check("midreset_no_stale", data_out, '0);
    wait_done(4, lat);
    check("midreset_new_latency", 512'(lat), 512'(LAT));
    check("midreset_new_out", data_out, expv);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
